// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response bus shared by the two pipeline requesters and the downstream port.
// The master drives the request fields; the slave returns addr_ok/data_ok/rdata.
interface sram_like_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter sharing one SRAM-like downstream port between the instruction and data
// requesters, with a single outstanding transaction at a time.
module sram_like_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    sram_like_arbiter_if.slave  inst,
    sram_like_arbiter_if.slave  data,
    sram_like_arbiter_if.master m
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;
    typedef enum logic {GntInst = 1'b0, GntData = 1'b1} grant_e;

    state_e            state_q, state_d;
    grant_e            grant_q, last_grant_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;

    logic any_req;
    logic pick_data;
    logic accept;
    logic resp_take;

    // Data wins a tie unless it was the last one served.
    always_comb begin
        any_req   = inst.req | data.req;
        pick_data = data.req & (~inst.req | (last_grant_q == GntInst));
        accept    = (state_q == StIdle) & any_req;
        resp_take = ((state_q == StReq) & m.addr_ok & m.data_ok) |
                    ((state_q == StWait) & m.data_ok);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_req) state_d = StReq;
            StReq:   if (m.addr_ok) state_d = m.data_ok ? StResp : StWait;
            StWait:  if (m.data_ok) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // addr_ok is gated by resetn so every output is quiet while reset is held.
    always_comb begin
        inst.addr_ok = resetn & accept & ~pick_data;
        data.addr_ok = resetn & accept & pick_data;
        inst.data_ok = (state_q == StResp) & (grant_q == GntInst);
        data.data_ok = (state_q == StResp) & (grant_q == GntData);
        inst.rdata   = inst_rdata_q;
        data.rdata   = data_rdata_q;
        m.req        = (state_q == StReq);
        m.wr         = wr_q;
        m.size       = size_q;
        m.addr       = addr_q;
        m.wdata      = wdata_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q      <= GntInst;
            last_grant_q <= GntInst;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (accept) begin
            grant_q      <= pick_data ? GntData : GntInst;
            last_grant_q <= pick_data ? GntData : GntInst;
            wr_q         <= pick_data ? data.wr : inst.wr;
            size_q       <= pick_data ? data.size : inst.size;
            addr_q       <= pick_data ? data.addr : inst.addr;
            wdata_q      <= pick_data ? data.wdata : inst.wdata;
        end
    end

    // Each requester keeps its last response until its own next one lands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else if (resp_take) begin
            if (grant_q == GntData) begin
                data_rdata_q <= m.rdata;
            end else begin
                inst_rdata_q <= m.rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized scoreboard bench for sram_like_arbiter: a transaction-level model predicts grants,
// downstream traffic and responses; separate monitor processes compare against the DUT.
module tb_sram_like_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct {
        bit          who;   // 1 = data requester
        bit          wr;
        bit [1:0]    size;
        bit [AW-1:0] addr;
        bit [DW-1:0] wdata;
        longint      start;
    } tx_t;

    typedef struct {
        bit [DW-1:0] rdata;
        longint      due;
    } rsp_t;

    logic   clk = 1'b0;
    logic   resetn;
    longint cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    bit     mon_en  = 1'b0;
    bit     rand_en = 1'b0;
    bit     model_last = 1'b0;
    longint free_cyc = 0;
    bit [DW-1:0] last_inst = '0;
    bit [DW-1:0] last_data = '0;

    tx_t  exp_m_q[$];
    rsp_t exp_inst_q[$];
    rsp_t exp_data_q[$];

    sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) inst_if ();
    sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) data_if ();
    sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

    sram_like_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .inst   (inst_if),
        .data   (data_if),
        .m      (m_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic complete(input tx_t t, input bit [DW-1:0] rd);
        rsp_t r;
        r.rdata = rd;
        r.due   = cyc + 1;
        if (t.who) exp_data_q.push_back(r);
        else       exp_inst_q.push_back(r);
        free_cyc = cyc + 2;
    endtask

    task automatic upd_inst(input bit acc);
        if (inst_if.req && !acc) begin
            if ($urandom_range(0, 15) == 0) inst_if.req = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
            inst_if.req   = 1'b1;
            inst_if.wr    = ($urandom_range(0, 15) == 0);
            inst_if.size  = 2'($urandom_range(0, 2));
            inst_if.addr  = $urandom;
            inst_if.wdata = $urandom;
        end else begin
            inst_if.req = 1'b0;
        end
    endtask

    task automatic upd_data(input bit acc);
        if (data_if.req && !acc) begin
            if ($urandom_range(0, 15) == 0) data_if.req = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
            data_if.req   = 1'b1;
            data_if.wr    = ($urandom_range(0, 1) == 0);
            data_if.size  = 2'($urandom_range(0, 2));
            data_if.addr  = $urandom;
            data_if.wdata = $urandom;
        end else begin
            data_if.req = 1'b0;
        end
    endtask

    // Requesters: hold until accepted, sometimes withdraw, sometimes re-request back to back.
    initial begin : req_drv
        bit acc_i, acc_d;
        forever begin
            @(negedge clk);
            acc_i = inst_if.req & inst_if.addr_ok;
            acc_d = data_if.req & data_if.addr_ok;
            @(posedge clk);
            #1;
            if (rand_en) begin
                upd_inst(acc_i);
                upd_data(acc_d);
            end
        end
    end

    // Reference arbiter: one transaction in flight, round-robin on a tie.
    initial begin : model
        bit  ei, ed;
        tx_t t;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ei = 1'b0;
                ed = 1'b0;
                if (cyc >= free_cyc && (inst_if.req || data_if.req)) begin
                    ed = data_if.req && (!inst_if.req || !model_last);
                    ei = !ed;
                    t.who   = ed;
                    t.wr    = ed ? data_if.wr : inst_if.wr;
                    t.size  = ed ? data_if.size : inst_if.size;
                    t.addr  = ed ? data_if.addr : inst_if.addr;
                    t.wdata = ed ? data_if.wdata : inst_if.wdata;
                    t.start = cyc + 1;
                    exp_m_q.push_back(t);
                    model_last = ed;
                    free_cyc   = 64'h7fff_ffff_ffff_ffff;
                end
                check("inst_addr_ok", inst_if.addr_ok, ei);
                check("data_addr_ok", data_if.addr_ok, ed);
            end
        end
    end

    // Downstream memory: random backpressure and latency, stray handshakes when idle.
    initial begin : responder
        tx_t cur;
        bit  busy, acked, a, d;
        int  a_wait, d_wait;
        bit [DW-1:0] rd;
        busy = 1'b0;
        acked = 1'b0;
        a_wait = 0;
        d_wait = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                a  = 1'b0;
                d  = 1'b0;
                rd = $urandom;
                if (!busy && exp_m_q.size() > 0 && exp_m_q[0].start <= cyc) begin
                    cur    = exp_m_q.pop_front();
                    busy   = 1'b1;
                    acked  = 1'b0;
                    a_wait = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 12)
                                                         : $urandom_range(0, 2);
                    d_wait = $urandom_range(0, 4);
                end
                if (!busy) begin
                    check("m_req_idle", m_if.req, 1'b0);
                    a = ($urandom_range(0, 7) == 0);
                    d = ($urandom_range(0, 7) == 0);
                end else if (!acked) begin
                    check("m_req", m_if.req, 1'b1);
                    check("m_wr", m_if.wr, cur.wr);
                    check("m_size", m_if.size, cur.size);
                    check("m_addr", m_if.addr, cur.addr);
                    check("m_wdata", m_if.wdata, cur.wdata);
                    if (a_wait == 0) a = 1'b1;
                    else a_wait--;
                    d = a ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
                    if (a) acked = 1'b1;
                    if (a && d) begin
                        complete(cur, rd);
                        busy = 1'b0;
                    end
                end else begin
                    check("m_req_wait", m_if.req, 1'b0);
                    if (d_wait == 0) begin
                        d = 1'b1;
                        complete(cur, rd);
                        busy = 1'b0;
                    end else begin
                        d_wait--;
                    end
                end
                m_if.addr_ok = a;
                m_if.data_ok = d;
                m_if.rdata   = rd;
            end
        end
    end

    initial begin : monitor
        rsp_t r;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (inst_if.data_ok) begin
                    if (exp_inst_q.size() == 0) begin
                        check("inst_data_ok_unexpected", inst_if.data_ok, 1'b0);
                    end else begin
                        r = exp_inst_q.pop_front();
                        check("inst_data_ok_cycle", cyc, r.due);
                        last_inst = r.rdata;
                    end
                end else if (exp_inst_q.size() > 0 && exp_inst_q[0].due <= cyc) begin
                    check("inst_data_ok_missing", inst_if.data_ok, 1'b1);
                    void'(exp_inst_q.pop_front());
                end
                check("inst_rdata", inst_if.rdata, last_inst);
                if (data_if.data_ok) begin
                    if (exp_data_q.size() == 0) begin
                        check("data_data_ok_unexpected", data_if.data_ok, 1'b0);
                    end else begin
                        r = exp_data_q.pop_front();
                        check("data_data_ok_cycle", cyc, r.due);
                        last_data = r.rdata;
                    end
                end else if (exp_data_q.size() > 0 && exp_data_q[0].due <= cyc) begin
                    check("data_data_ok_missing", data_if.data_ok, 1'b1);
                    void'(exp_data_q.pop_front());
                end
                check("data_rdata", data_if.rdata, last_data);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check_quiet(input string tag);
        check({tag, "_inst_addr_ok"}, inst_if.addr_ok, 1'b0);
        check({tag, "_data_addr_ok"}, data_if.addr_ok, 1'b0);
        check({tag, "_inst_data_ok"}, inst_if.data_ok, 1'b0);
        check({tag, "_data_data_ok"}, data_if.data_ok, 1'b0);
        check({tag, "_inst_rdata"}, inst_if.rdata, '0);
        check({tag, "_data_rdata"}, data_if.rdata, '0);
        check({tag, "_m_req"}, m_if.req, 1'b0);
        check({tag, "_m_wr"}, m_if.wr, 1'b0);
        check({tag, "_m_size"}, m_if.size, '0);
        check({tag, "_m_addr"}, m_if.addr, '0);
        check({tag, "_m_wdata"}, m_if.wdata, '0);
    endtask

    initial begin : main
        int guard;
        resetn        = 1'b0;
        m_if.addr_ok  = 1'b0;
        m_if.data_ok  = 1'b0;
        m_if.rdata    = '0;
        // Both requesters already waiting when reset lifts: data must win first.
        inst_if.req   = 1'b1;
        inst_if.wr    = 1'b0;
        inst_if.size  = 2'd2;
        inst_if.addr  = 32'hBFC0_0000;
        inst_if.wdata = '0;
        data_if.req   = 1'b1;
        data_if.wr    = 1'b1;
        data_if.size  = 2'd0;
        data_if.addr  = 32'h8000_1003;
        data_if.wdata = 32'h0000_00AB;
        repeat (3) @(negedge clk);
        check_quiet("reset");

        @(posedge clk);
        #1;
        resetn  = 1'b1;
        mon_en  = 1'b1;
        rand_en = 1'b1;
        repeat (4000) @(posedge clk);

        #2;
        rand_en     = 1'b0;
        inst_if.req = 1'b0;
        data_if.req = 1'b0;
        guard = 0;
        while ((exp_m_q.size() > 0 || exp_inst_q.size() > 0 || exp_data_q.size() > 0)
               && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        check("drain_timeout", guard < 200, 1'b1);

        // Reset while the transaction is waiting for its response.
        @(posedge clk);
        mon_en = 1'b0;
        @(negedge clk);
        #1;
        m_if.addr_ok = 1'b0;
        m_if.data_ok = 1'b0;
        @(posedge clk);
        #1;
        inst_if.req  = 1'b1;
        inst_if.wr   = 1'b0;
        inst_if.size = 2'd2;
        inst_if.addr = 32'hBFC0_0000;
        @(negedge clk);
        check("dir_inst_addr_ok", inst_if.addr_ok, 1'b1);
        @(posedge clk);
        #1;
        inst_if.req = 1'b0;
        @(negedge clk);
        check("dir_m_req", m_if.req, 1'b1);
        check("dir_m_addr", m_if.addr, 32'hBFC0_0000);
        m_if.addr_ok = 1'b1;
        @(posedge clk);
        #1;
        m_if.addr_ok = 1'b0;
        @(negedge clk);
        check("dir_wait_m_req", m_if.req, 1'b0);
        resetn = 1'b0;
        #1;
        check_quiet("midrst");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        m_if.data_ok = 1'b1;
        m_if.rdata   = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        m_if.data_ok = 1'b0;
        @(negedge clk);
        check("stray_inst_data_ok", inst_if.data_ok, 1'b0);
        check("stray_data_data_ok", data_if.data_ok, 1'b0);
        check("stray_inst_rdata", inst_if.rdata, '0);
        @(posedge clk);
        #1;
        inst_if.req = 1'b1;
        data_if.req = 1'b1;
        @(negedge clk);
        check("post_rst_data_addr_ok", data_if.addr_ok, 1'b1);
        check("post_rst_inst_addr_ok", inst_if.addr_ok, 1'b0);
        @(posedge clk);
        #1;
        inst_if.req = 1'b0;
        data_if.req = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
